adc_capture_packer: RTL and testbench

Acquisition front end clocked by the 24 MHz PLL output. It generates the conversion clock for an external 8-bit parallel ADC and samples one byte per conversion period. It packs each pair of samples into a 16-bit word and buffers the words in a small FIFO. The FIFO feeds the PSRAM write stage through a valid/ready handshake.

---
 rtl/adc_capture_packer.sv | 175 +++++++++++++++++
 tb/tb_adc_capture_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_packer.sv
// ADC conversion-clock generator, byte sampler, 2:1 word packer and FWFT word FIFO.
// Optional build macro ADC_CAPTURE_TEST_PATTERN_EN replaces adc_data with an internal byte counter.
module adc_capture_packer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_words,
  output logic             adc_clk,
  input  logic [7:0]       adc_data,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF  = CLK_DIV / 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             adc_clk_q, adc_clk_d;
  logic             slot_q, slot_d;
  logic [7:0]       lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic [PW-1:0] occ;
  logic          empty, full, start_ok, strobe, word_done, push_ok, drop, pop;
  logic [7:0]    sample;
  logic [15:0]   word;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [7:0] pat_q, pat_d;
  logic       unused_adc_data;
  assign unused_adc_data = ^adc_data;
  assign sample          = pat_q;
`else
  assign sample = adc_data;
`endif

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign empty     = (occ == '0);
  assign full      = (occ == PW'(FIFO_DEPTH));
  assign start_ok  = start && (state_q == S_IDLE);
  assign strobe    = (state_q == S_CAPTURE) && (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign word      = {sample, lo_q};
  assign word_done = strobe && slot_q;
  // Full is judged before this edge's pop, so a stalled-then-released FIFO still drops.
  assign push_ok   = word_done && !full;
  assign drop      = word_done && full;
  assign pop       = !empty && m_ready;

  assign adc_clk  = adc_clk_q;
  assign m_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid  = !empty;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

  // Next-state, divider, packer and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    slot_d     = slot_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    pat_d      = pat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cnt_d      = n_words;
          slot_d     = 1'b0;
          overflow_d = 1'b0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
          pat_d      = 8'd0;
`endif
          if (n_words != '0) state_d = S_CAPTURE;
          else               done_d  = 1'b1;
        end
      end
      S_CAPTURE: begin
        div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);
        if (strobe) begin
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
          pat_d = pat_q + 8'd1;
`endif
          if (!slot_q) begin
            lo_d   = sample;
            slot_d = 1'b1;
          end else begin
            slot_d = 1'b0;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (drop) overflow_d = 1'b1;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = word;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    busy_d    = (state_d != S_IDLE);
    adc_clk_d = (state_d == S_CAPTURE) && (div_cnt_d < DIV_W'(HALF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      adc_clk_q  <= 1'b0;
      slot_q     <= 1'b0;
      lo_q       <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      pat_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      adc_clk_q  <= adc_clk_d;
      slot_q     <= slot_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      pat_q      <= pat_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_capture_packer.sv
// Directed self-checking bench for adc_capture_packer (CLK_DIV=4, FIFO_DEPTH=4).
module tb_adc_capture_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n_words;
  logic        adc_clk;
  logic [7:0]  adc_data;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int          passed = 0;
  int          total  = 0;
  int          ecnt   = 0;
  int          rise_cnt = 0;
  int          r0;
  logic [15:0] got[$];

  adc_capture_packer #(.CLK_DIV(4), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_words(n_words),
    .adc_clk(adc_clk), .adc_data(adc_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Words accepted by the consumer (popped on the following rising edge).
  always @(negedge clk) if (rst_n === 1'b1 && m_valid && m_ready) got.push_back(m_data);
  always @(posedge adc_clk) rise_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sample byte 0x11*k is presented for the k-th strobe edge (edge 4k after start).
  function automatic logic [7:0] data_for(input int e);
    int s;
    s = (e + 3) / 4;
    return 8'(s * 17);
  endfunction

  task automatic step();
    adc_data = data_for(ecnt + 1);
    @(posedge clk); #1;
    ecnt++;
  endtask

  task automatic do_start(input logic [15:0] n);
    n_words = n;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ecnt  = 0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done !== 1'b1; i++) step();
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_words = '0; adc_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_adc_clk", 32'(adc_clk), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    m_ready = 1'b1;
    got.delete();
    do_start(16'd130);
    wait_done(1200);
    check("pat_count", 32'(got.size()), 32'd130);
    for (int i = 0; i < 130; i++) begin
      logic [15:0] exp_w;
      exp_w = {8'(2 * i + 1), 8'(2 * i)};
      check("pat_word", 32'(got[i]), 32'(exp_w));
    end
    check("pat_last", 32'(got[127]), 32'h0000FFFE);
    check("pat_wrap", 32'(got[128]), 32'h00000100);
`else
    // Basic 3-word run with free-running consumer.
    m_ready = 1'b1;
    got.delete();
    do_start(16'd3);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_adc_clk_e0", 32'(adc_clk), 32'd1);
    check("t1_valid_e0", 32'(m_valid), 32'd0);
    repeat (7) step();
    check("t1_valid_e7", 32'(m_valid), 32'd0);
    step();
    check("t1_valid_e8", 32'(m_valid), 32'd1);
    check("t1_data_e8", 32'(m_data), 32'h2211);
    repeat (16) step();
    check("t1_busy_e24", 32'(busy), 32'd1);
    check("t1_adc_clk_e24", 32'(adc_clk), 32'd0);
    step();
    check("t1_done_e25", 32'(done), 32'd0);
    step();
    check("t1_done_e26", 32'(done), 32'd1);
    check("t1_busy_e26", 32'(busy), 32'd0);
    step();
    check("t1_done_e27", 32'(done), 32'd0);
    check("t1_count", 32'(got.size()), 32'd3);
    check("t1_w0", 32'(got[0]), 32'h2211);
    check("t1_w1", 32'(got[1]), 32'h4433);
    check("t1_w2", 32'(got[2]), 32'h6655);
    check("t1_overflow", 32'(overflow), 32'd0);

    // adc_clk waveform for 2 words; a start mid-run must be ignored.
    got.delete();
    r0 = rise_cnt;
    do_start(16'd2);
    check("t2_adc_clk_e0", 32'(adc_clk), 32'd1);
    for (int e = 1; e <= 17; e++) begin
      if (e == 5) begin start = 1'b1; n_words = 16'd9; end
      step();
      start = 1'b0;
      check("t2_adc_clk", 32'(adc_clk), (e < 16 && (e % 4) < 2) ? 32'd1 : 32'd0);
    end
    wait_done(10);
    check("t2_rises", 32'(rise_cnt - r0), 32'd4);
    check("t2_count", 32'(got.size()), 32'd2);
    check("t2_w1", 32'(got[1]), 32'h4433);

    // Back-pressure: 6 words into a depth-4 FIFO.
    got.delete();
    m_ready = 1'b0;
    do_start(16'd6);
    repeat (32) step();
    check("t3_ovf_e32", 32'(overflow), 32'd0);
    repeat (8) step();
    check("t3_ovf_e40", 32'(overflow), 32'd1);
    check("t3_hold_data", 32'(m_data), 32'h2211);
    check("t3_hold_valid", 32'(m_valid), 32'd1);
    repeat (8) step();
    check("t3_busy_e48", 32'(busy), 32'd1);
    check("t3_adc_clk_e48", 32'(adc_clk), 32'd0);
    repeat (4) step();
    check("t3_busy_stall", 32'(busy), 32'd1);
    check("t3_done_stall", 32'(done), 32'd0);
    m_ready = 1'b1;
    wait_done(20);
    check("t3_count", 32'(got.size()), 32'd4);
    check("t3_w0", 32'(got[0]), 32'h2211);
    check("t3_w3", 32'(got[3]), 32'h8877);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Zero-length request.
    r0 = rise_cnt;
    do_start(16'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    step();
    check("t4_done_gone", 32'(done), 32'd0);
    repeat (4) step();
    check("t4_no_adc_clk", 32'(rise_cnt - r0), 32'd0);

    // Asynchronous reset mid-capture, then a fresh run.
    m_ready = 1'b0;
    do_start(16'd3);
    repeat (20) step();
    check("t5_valid_pre", 32'(m_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_adc_clk", 32'(adc_clk), 32'd0);
    check("t5_m_valid", 32'(m_valid), 32'd0);
    check("t5_m_data", 32'(m_data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    got.delete();
    do_start(16'd1);
    check("t5_busy_new", 32'(busy), 32'd1);
    repeat (8) step();
    check("t5_valid_e8", 32'(m_valid), 32'd1);
    check("t5_data_e8", 32'(m_data), 32'h2211);
    wait_done(10);
    check("t5_count", 32'(got.size()), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
